// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, requester ids and the read-after-write compare
package regfile_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int STARVE_MAX = 3;
   localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;
   typedef enum logic [1:0] {REQ_NONE, REQ_ALU, REQ_MEM} req_e;
   // $zero is never a hazard: it reads as constant zero whatever is in flight
   function automatic logic raw_hit(input logic [ADDR_W-1:0] rd, input logic rw,
                                    input logic [ADDR_W-1:0] wr, input logic av,
                                    input logic [ADDR_W-1:0] ar, input logic mv,
                                    input logic [ADDR_W-1:0] mr);
      return (rd != ZERO_REG) && ((rw && wr == rd) || (av && ar == rd) || (mv && mr == rd));
   endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requests, register file write port and hazard lookups
interface regfile_wb_arbiter_if #(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W
);
   logic              stall;
   logic              alu_valid;
   logic              alu_ready;
   logic [ADDR_W-1:0] alu_reg;
   logic [DATA_W-1:0] alu_data;
   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_reg;
   logic [DATA_W-1:0] mem_data;
   logic              RegWrite;
   logic [ADDR_W-1:0] write_reg;
   logic [DATA_W-1:0] write_data;
   logic [ADDR_W-1:0] read_reg_1;
   logic [ADDR_W-1:0] read_reg_2;
   logic              hazard_1;
   logic              hazard_2;
   modport slave (
      input  stall, alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
             read_reg_1, read_reg_2,
      output alu_ready, mem_ready, RegWrite, write_reg, write_data, hazard_1, hazard_2
   );
   modport master (
      output stall, alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
             read_reg_1, read_reg_2,
      input  alu_ready, mem_ready, RegWrite, write_reg, write_data, hazard_1, hazard_2
   );
endinterface

// File: rtl/wb_priority_sel.sv
// wb_priority_sel: mem-over-alu grant with a consecutive-loss counter that forces an alu win
module wb_priority_sel import regfile_pkg::*; #(
   parameter int STARVE_MAX = regfile_pkg::STARVE_MAX
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       stall_i,
   input  logic       alu_valid_i,
   input  logic       mem_valid_i,
   output logic [1:0] grant_o,
   output req_e       req_o
);
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic alu_win, mem_win;
   // only contended mem wins count as alu losses, so the counter cannot pass STARVE_MAX
   always_comb begin
      alu_win = !stall_i && alu_valid_i && (!mem_valid_i || starve_cnt_q == CNT_W'(STARVE_MAX));
      mem_win = !stall_i && mem_valid_i && !alu_win;
      starve_cnt_d = alu_win ? '0 : (mem_win && alu_valid_i) ? starve_cnt_q + 1'b1 : starve_cnt_q;
      grant_o = {mem_win, alu_win};
      req_o = alu_win ? REQ_ALU : mem_win ? REQ_MEM : REQ_NONE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) starve_cnt_q <= '0;
      else starve_cnt_q <= starve_cnt_d;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between alu and load writebacks
// and flags read-after-write hazards for decode
module regfile_wb_arbiter import regfile_pkg::*; #(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W,
   parameter int STARVE_MAX = regfile_pkg::STARVE_MAX
) (
   input logic clk,
   input logic rst_n,
   regfile_wb_arbiter_if.slave bus
);
   logic [1:0]        grant;
   req_e              req;
   logic              regwrite_q, regwrite_d;
   logic [ADDR_W-1:0] write_reg_q, write_reg_d, sel_reg;
   logic [DATA_W-1:0] write_data_q, write_data_d, sel_data;
   wb_priority_sel #(.STARVE_MAX(STARVE_MAX)) u_sel (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall_i     (bus.stall),
      .alu_valid_i (bus.alu_valid),
      .mem_valid_i (bus.mem_valid),
      .grant_o     (grant),
      .req_o       (req)
   );
   // a $zero write is accepted and latched but never enables the register file
   always_comb begin
      sel_reg = (req == REQ_MEM) ? bus.mem_reg : bus.alu_reg;
      sel_data = (req == REQ_MEM) ? bus.mem_data : bus.alu_data;
      regwrite_d = |grant && sel_reg != ADDR_W'(ZERO_REG);
      write_reg_d = |grant ? sel_reg : write_reg_q;
      write_data_d = |grant ? sel_data : write_data_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         regwrite_q <= 1'b0;
         write_reg_q <= '0;
         write_data_q <= '0;
      end else begin
         regwrite_q <= regwrite_d;
         write_reg_q <= write_reg_d;
         write_data_q <= write_data_d;
      end
   assign bus.alu_ready = grant[0];
   assign bus.mem_ready = grant[1];
   assign bus.RegWrite = regwrite_q;
   assign bus.write_reg = write_reg_q;
   assign bus.write_data = write_data_q;
   assign bus.hazard_1 = raw_hit(bus.read_reg_1, regwrite_q, write_reg_q, bus.alu_valid,
                                 bus.alu_reg, bus.mem_valid, bus.mem_reg);
   assign bus.hazard_2 = raw_hit(bus.read_reg_2, regwrite_q, write_reg_q, bus.alu_valid,
                                 bus.alu_reg, bus.mem_valid, bus.mem_reg);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios plus a randomized run against a register-file model
module tb_regfile_wb_arbiter;
   import regfile_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_checks = 0;
   int n_fail = 0;
   regfile_wb_arbiter_if bus();
   regfile_wb_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   task automatic set_req(input logic st, input logic av, input logic [4:0] ar,
                          input logic [31:0] ad, input logic mv, input logic [4:0] mr,
                          input logic [31:0] md);
      bus.stall = st;
      bus.alu_valid = av;
      bus.alu_reg = ar;
      bus.alu_data = ad;
      bus.mem_valid = mv;
      bus.mem_reg = mr;
      bus.mem_data = md;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      bus.read_reg_1 = '0;
      bus.read_reg_2 = '0;
      set_req(0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({bus.RegWrite, bus.write_reg, bus.write_data} !== 38'd0) begin
         n_fail++;
         $display("FAIL reset_init: got %h expected 0", {bus.RegWrite, bus.write_reg, bus.write_data});
      end
      @(negedge clk) rst_n = 1'b1;
      set_req(0, 1, 5'd9, 32'hAAAA_5555, 0, 0, 0);
      tick;
      n_checks++;
      if ({bus.RegWrite, bus.write_reg, bus.write_data} !== {1'b1, 5'd9, 32'hAAAA_5555}) begin
         n_fail++;
         $display("FAIL reset_pre_write: got %h expected %h",
                  {bus.RegWrite, bus.write_reg, bus.write_data}, {1'b1, 5'd9, 32'hAAAA_5555});
      end
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.RegWrite, bus.write_reg, bus.write_data} !== 38'd0) begin
         n_fail++;
         $display("FAIL reset_async: got %h expected 0", {bus.RegWrite, bus.write_reg, bus.write_data});
      end
      set_req(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_single_alu;
      set_req(0, 1, 5'd8, 32'hDEAD_BEEF, 0, 0, 0);
      n_checks++;
      if ({bus.alu_ready, bus.mem_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL single_alu_ready: got %b expected 10", {bus.alu_ready, bus.mem_ready});
      end
      tick;
      set_req(0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({bus.RegWrite, bus.write_reg, bus.write_data} !== {1'b1, 5'd8, 32'hDEAD_BEEF}) begin
         n_fail++;
         $display("FAIL single_alu_write: got %h expected %h",
                  {bus.RegWrite, bus.write_reg, bus.write_data}, {1'b1, 5'd8, 32'hDEAD_BEEF});
      end
      tick;
      n_checks++;
      if ({bus.RegWrite, bus.write_reg, bus.write_data} !== {1'b0, 5'd8, 32'hDEAD_BEEF}) begin
         n_fail++;
         $display("FAIL single_alu_idle_hold: got %h expected %h",
                  {bus.RegWrite, bus.write_reg, bus.write_data}, {1'b0, 5'd8, 32'hDEAD_BEEF});
      end
   endtask

   task automatic test_starvation;
      logic [7:0] alu_turn = 8'b1000_1000;
      int na = 0;
      int nm = 0;
      for (int i = 0; i < 8; i++) begin
         set_req(0, 1, 5'd10, 32'hA000_0000 + na, 1, 5'd11, 32'hB000_0000 + nm);
         n_checks++;
         if ({bus.alu_ready, bus.mem_ready} !== {alu_turn[i], !alu_turn[i]}) begin
            n_fail++;
            $display("FAIL starve_grant_%0d: got %b expected %b", i,
                     {bus.alu_ready, bus.mem_ready}, {alu_turn[i], !alu_turn[i]});
         end
         tick;
         n_checks++;
         if ({bus.RegWrite, bus.write_reg, bus.write_data} !== (alu_turn[i] ?
             {1'b1, 5'd10, 32'hA000_0000 + na} : {1'b1, 5'd11, 32'hB000_0000 + nm})) begin
            n_fail++;
            $display("FAIL starve_write_%0d: got %h", i, {bus.RegWrite, bus.write_reg, bus.write_data});
         end
         if (alu_turn[i]) na++;
         else nm++;
      end
      set_req(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_zero;
      set_req(0, 0, 0, 0, 1, 5'd0, 32'h5);
      n_checks++;
      if ({bus.alu_ready, bus.mem_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL zero_ready: got %b expected 01", {bus.alu_ready, bus.mem_ready});
      end
      tick;
      set_req(0, 1, 5'd3, 32'h33, 0, 0, 0);
      n_checks++;
      if ({bus.RegWrite, bus.write_reg, bus.write_data} !== {1'b0, 5'd0, 32'h5}) begin
         n_fail++;
         $display("FAIL zero_drop: got %h expected %h",
                  {bus.RegWrite, bus.write_reg, bus.write_data}, {1'b0, 5'd0, 32'h5});
      end
      tick;
      set_req(0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({bus.RegWrite, bus.write_reg, bus.write_data} !== {1'b1, 5'd3, 32'h33}) begin
         n_fail++;
         $display("FAIL zero_next_write: got %h expected %h",
                  {bus.RegWrite, bus.write_reg, bus.write_data}, {1'b1, 5'd3, 32'h33});
      end
   endtask

   task automatic test_stall;
      logic [2:0] alu_turn = 3'b100;
      int nm = 1;
      set_req(0, 1, 5'd12, 32'hC1, 1, 5'd13, 32'hD0);
      n_checks++;
      if ({bus.alu_ready, bus.mem_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL stall_pre_grant: got %b expected 01", {bus.alu_ready, bus.mem_ready});
      end
      tick;
      for (int i = 0; i < 4; i++) begin
         set_req(1, 1, 5'd12, 32'hC1, 1, 5'd13, 32'hD1);
         n_checks++;
         if ({bus.alu_ready, bus.mem_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL stall_ready_%0d: got %b expected 00", i, {bus.alu_ready, bus.mem_ready});
         end
         tick;
         n_checks++;
         if (bus.RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_regwrite_%0d: got %b expected 0", i, bus.RegWrite);
         end
      end
      // one contended loss before the stall: two more mem wins, then the forced alu win
      for (int i = 0; i < 3; i++) begin
         set_req(0, 1, 5'd12, 32'hC1, 1, 5'd13, 32'hD0 + nm);
         n_checks++;
         if ({bus.alu_ready, bus.mem_ready} !== {alu_turn[i], !alu_turn[i]}) begin
            n_fail++;
            $display("FAIL stall_resume_%0d: got %b expected %b", i,
                     {bus.alu_ready, bus.mem_ready}, {alu_turn[i], !alu_turn[i]});
         end
         tick;
         if (!alu_turn[i]) nm++;
      end
      set_req(0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({bus.RegWrite, bus.write_reg, bus.write_data} !== {1'b1, 5'd12, 32'hC1}) begin
         n_fail++;
         $display("FAIL stall_resume_write: got %h expected %h",
                  {bus.RegWrite, bus.write_reg, bus.write_data}, {1'b1, 5'd12, 32'hC1});
      end
   endtask

   task automatic test_hazard;
      set_req(0, 1, 5'd5, 32'h55, 0, 0, 0);
      tick;
      bus.read_reg_1 = 5'd5;
      bus.read_reg_2 = 5'd0;
      set_req(0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({bus.hazard_1, bus.hazard_2} !== 2'b10) begin
         n_fail++;
         $display("FAIL hazard_inflight: got %b expected 10", {bus.hazard_1, bus.hazard_2});
      end
      bus.read_reg_2 = 5'd7;
      set_req(1, 1, 5'd7, 32'h77, 0, 0, 0);
      n_checks++;
      if ({bus.hazard_1, bus.hazard_2} !== 2'b11) begin
         n_fail++;
         $display("FAIL hazard_pending: got %b expected 11", {bus.hazard_1, bus.hazard_2});
      end
      bus.read_reg_2 = 5'd0;
      set_req(1, 0, 0, 0, 1, 5'd0, 32'h1);
      n_checks++;
      if (bus.hazard_2 !== 1'b0) begin
         n_fail++;
         $display("FAIL hazard_zero: got %b expected 0", bus.hazard_2);
      end
      set_req(0, 0, 0, 0, 0, 0, 0);
      tick;
   endtask

   task automatic test_random;
      logic [31:0] rf_exp [32];
      logic [31:0] rf_obs [32];
      int alu_losses = 0;
      logic av = 0, mv = 0, st, ea, em, exp_rw = 0, h1, h2;
      logic [4:0] ar = 0, mr = 0, rr1, rr2, exp_wr = 0, wreg;
      logic [31:0] ad = 0, md = 0, exp_wd = 0, wdata;
      for (int i = 0; i < 32; i++) begin
         rf_exp[i] = '0;
         rf_obs[i] = '0;
      end
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      for (int c = 0; c < 400; c++) begin
         st = ($urandom_range(7) == 0);
         if (!av) begin
            av = 1'($urandom_range(1));
            ar = 5'($urandom_range(7));
            ad = $urandom;
         end
         if (!mv) begin
            mv = 1'($urandom_range(1));
            mr = 5'($urandom_range(7));
            md = $urandom;
         end
         rr1 = 5'($urandom_range(7));
         rr2 = 5'($urandom_range(7));
         bus.read_reg_1 = rr1;
         bus.read_reg_2 = rr2;
         set_req(st, av, ar, ad, mv, mr, md);
         ea = !st && av && (!mv || alu_losses == STARVE_MAX);
         em = !st && mv && !ea;
         h1 = rr1 != 0 && ((exp_rw && exp_wr == rr1) || (av && ar == rr1) || (mv && mr == rr1));
         h2 = rr2 != 0 && ((exp_rw && exp_wr == rr2) || (av && ar == rr2) || (mv && mr == rr2));
         n_checks++;
         if ({bus.alu_ready, bus.mem_ready, bus.hazard_1, bus.hazard_2} !== {ea, em, h1, h2}) begin
            n_fail++;
            $display("FAIL rand_comb_%0d: got %b expected %b", c,
                     {bus.alu_ready, bus.mem_ready, bus.hazard_1, bus.hazard_2}, {ea, em, h1, h2});
         end
         if (ea) alu_losses = 0;
         else if (em && av) alu_losses++;
         wreg = ea ? ar : mr;
         wdata = ea ? ad : md;
         exp_rw = (ea || em) && wreg != 0;
         if (ea || em) begin
            exp_wr = wreg;
            exp_wd = wdata;
            if (wreg != 0) rf_exp[wreg] = wdata;
         end
         if (ea) av = 0;
         if (em) mv = 0;
         tick;
         n_checks++;
         if ({bus.RegWrite, bus.write_reg, bus.write_data} !== {exp_rw, exp_wr, exp_wd}) begin
            n_fail++;
            $display("FAIL rand_write_%0d: got %h expected %h", c,
                     {bus.RegWrite, bus.write_reg, bus.write_data}, {exp_rw, exp_wr, exp_wd});
         end
         if (bus.RegWrite === 1'b1) rf_obs[bus.write_reg] = bus.write_data;
      end
      set_req(0, 0, 0, 0, 0, 0, 0);
      for (int r = 0; r < 32; r++) begin
         n_checks++;
         if (rf_obs[r] !== rf_exp[r]) begin
            n_fail++;
            $display("FAIL rand_regfile_x%0d: got %h expected %h", r, rf_obs[r], rf_exp[r]);
         end
      end
   endtask

   initial begin
      test_reset;
      test_single_alu;
      test_starvation;
      test_zero;
      test_stall;
      test_hazard;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
